// File: rtl/imem_boot_ctrl.sv
// Boot controller for the RV64 instruction memory: loads a program word-by-word as
// little-endian byte writes, then releases the core and watches its PC for halt/error.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = 2 ** (ADDR_W - 2)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [63:0]       program_counter_input,
    output logic              core_run,
    output logic [ADDR_W-2:0] num_instructions,
    output logic              halt,
    output logic [1:0]        error
);

    localparam int unsigned CNT_W  = ADDR_W - 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_PC_RANGE = 2'd2;
    localparam logic [1:0] ERR_PC_ALIGN = 2'd3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE0,
        S_WRITE1,
        S_WRITE2,
        S_WRITE3,
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_word;
    logic               r_last;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_wdata;
    logic               r_halt;
    logic [1:0]         r_error;

    logic               w_accept;
    logic               w_pc_range_bad;
    logic               w_pc_misaligned;
    logic [CNT_W-1:0]   w_pc_widx;
    logic               w_pc_at_end;
    logic [ADDR_W-1:0]  w_word_base;

    assign w_accept        = load_valid && (r_state == S_LOAD);
    assign w_pc_range_bad  = |program_counter_input[63:ADDR_W];
    assign w_pc_misaligned = |program_counter_input[1:0];
    assign w_pc_widx       = CNT_W'(program_counter_input[ADDR_W-1:2]);
    // RUN is only entered with count >= 1, so count-1 never wraps here
    assign w_pc_at_end     = w_pc_widx >= (r_count - CNT_W'(1));
    assign w_word_base     = ADDR_W'({r_count[WIDX_W-1:0], 2'b00});

    // Sequencer: load handshake, byte write burst, PC monitoring
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halt      <= 1'b0;
            r_error     <= ERR_NONE;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_count == MAX_CNT) begin
                            r_state <= S_ERR;
                            r_error <= ERR_OVERFLOW;
                        end else begin
                            r_state     <= S_WRITE0;
                            r_word      <= load_data;
                            r_last      <= load_last;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_base;
                            r_mem_wdata <= load_data[7:0];
                        end
                    end
                end
                S_WRITE0: begin
                    r_state     <= S_WRITE1;
                    r_mem_addr  <= w_word_base + ADDR_W'(1);
                    r_mem_wdata <= r_word[15:8];
                end
                S_WRITE1: begin
                    r_state     <= S_WRITE2;
                    r_mem_addr  <= w_word_base + ADDR_W'(2);
                    r_mem_wdata <= r_word[23:16];
                end
                S_WRITE2: begin
                    r_state     <= S_WRITE3;
                    r_mem_addr  <= w_word_base + ADDR_W'(3);
                    r_mem_wdata <= r_word[31:24];
                end
                S_WRITE3: begin
                    r_mem_we <= 1'b0;
                    r_count  <= r_count + CNT_W'(1);
                    r_state  <= r_last ? S_RUN : S_LOAD;
                end
                S_RUN: begin
                    if (w_pc_range_bad) begin
                        r_state <= S_ERR;
                        r_error <= ERR_PC_RANGE;
                    end else if (w_pc_misaligned) begin
                        r_state <= S_ERR;
                        r_error <= ERR_PC_ALIGN;
                    end else if (w_pc_at_end) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign load_ready       = (r_state == S_LOAD);
    assign core_run         = (r_state == S_RUN);
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign num_instructions = r_count;
    assign halt             = r_halt;
    assign error            = r_error;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: default-size instance plus a MAX_WORDS=4 instance
// sharing the same stimulus; a byte-array model captures memory writes.
module tb_imem_boot_ctrl;

    localparam int unsigned ADDR_W = 14;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic [63:0] pc;

    logic              d_load_ready, d_mem_we, d_core_run, d_halt;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [7:0]        d_mem_wdata;
    logic [ADDR_W-2:0] d_num;
    logic [1:0]        d_error;

    logic              s_load_ready, s_mem_we, s_core_run, s_halt;
    logic [ADDR_W-1:0] s_mem_addr;
    logic [7:0]        s_mem_wdata;
    logic [ADDR_W-2:0] s_num;
    logic [1:0]        s_error;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int s_we_cnt = 0;
    logic [7:0] tb_mem [0:(1<<ADDR_W)-1];

    always #5 clock = ~clock;

    imem_boot_ctrl #(.ADDR_W(ADDR_W)) u_dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(d_load_ready),
        .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
        .program_counter_input(pc),
        .core_run(d_core_run), .num_instructions(d_num),
        .halt(d_halt), .error(d_error)
    );

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(4)) u_small (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(s_load_ready),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .program_counter_input(pc),
        .core_run(s_core_run), .num_instructions(s_num),
        .halt(s_halt), .error(s_error)
    );

    always @(posedge clock) begin
        if (d_mem_we) begin
            tb_mem[d_mem_addr] <= d_mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (s_mem_we) s_we_cnt <= s_we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Offers one word, returns sampling the WRITE3 cycle of that word
    task automatic load_word(input logic [31:0] w, input logic last);
        int waited = 0;
        load_valid = 1'b1; load_data = w; load_last = last;
        while (!d_load_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!d_load_ready) check("ready_timeout", 64'd0, 64'd1);
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tick();
        tick();
        tick();
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {tb_mem[a+3], tb_mem[a+2], tb_mem[a+1], tb_mem[a]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] wv [5];
        int          rdy_at [5];
        int          nrdy, idx, base;
        logic        was;

        wv[0] = 32'h11223344; wv[1] = 32'h55667788; wv[2] = 32'h99AABBCC;
        wv[3] = 32'hDDEEFF00; wv[4] = 32'h0F1E2D3C;
        pc = '0;

        // Reset state
        do_reset();
        check("rst_ready", d_load_ready, 1);
        check("rst_run",   d_core_run, 0);
        check("rst_halt",  d_halt, 0);
        check("rst_error", d_error, 0);
        check("rst_we",    d_mem_we, 0);
        check("rst_addr",  d_mem_addr, 0);
        check("rst_wdata", d_mem_wdata, 0);
        check("rst_num",   d_num, 0);

        // Three-word program, then run to halt
        base = we_cnt;
        load_word(32'h002080B3, 1'b0); tick();
        load_word(32'h40208133, 1'b0); tick();
        load_word(32'h00103023, 1'b1);
        check("w3_we",  d_mem_we, 1);
        check("w3_run", d_core_run, 0);
        tick();
        check("ld3_run",   d_core_run, 1);
        check("ld3_we",    d_mem_we, 0);
        check("ld3_ready", d_load_ready, 0);
        check("ld3_wecnt", we_cnt - base, 12);
        check("ld3_num",   d_num, 3);
        check("ld3_b0", tb_mem[0], 8'hB3);
        check("ld3_b1", tb_mem[1], 8'h80);
        check("ld3_b2", tb_mem[2], 8'h20);
        check("ld3_b3", tb_mem[3], 8'h00);
        check("ld3_w1", word_at(4), 32'h40208133);
        check("ld3_b8", tb_mem[8], 8'h23);
        check("ld3_b9", tb_mem[9], 8'h30);
        check("ld3_b10", tb_mem[10], 8'h10);
        check("ld3_b11", tb_mem[11], 8'h00);
        pc = 64'd0; tick();
        check("run_pc0", d_core_run, 1);
        pc = 64'd4; tick();
        check("run_pc4", d_core_run, 1);
        check("run_pc4_halt", d_halt, 0);
        pc = 64'd8; tick();
        check("halt_set", d_halt, 1);
        check("halt_run", d_core_run, 0);
        pc = 64'd12; tick();
        check("halt_sticky1", d_halt, 1);
        pc = 64'h4000; tick();
        check("halt_sticky2", d_halt, 1);
        check("halt_noerr", d_error, 0);

        // PC out of range
        do_reset();
        pc = 64'h4000;
        load_word(32'h00000013, 1'b1); tick();
        check("rng_run", d_core_run, 1);
        tick();
        check("rng_err",   d_error, 2);
        check("rng_run0",  d_core_run, 0);
        check("rng_ready", d_load_ready, 0);
        check("rng_halt",  d_halt, 0);

        // PC misaligned
        do_reset();
        pc = 64'h6;
        load_word(32'h00000013, 1'b1); tick();
        tick();
        check("mis_err",  d_error, 3);
        check("mis_run0", d_core_run, 0);

        // Back-to-back stream with load_valid held high
        do_reset();
        pc = 64'h10;
        base = we_cnt;
        idx = 0; nrdy = 0;
        load_valid = 1'b1; load_data = wv[0]; load_last = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            was = d_load_ready;
            if (was) begin
                if (nrdy < 5) rdy_at[nrdy] = cyc;
                nrdy++;
            end
            tick();
            if (was) begin
                idx++;
                if (idx < 5) begin
                    load_data = wv[idx];
                    load_last = (idx == 4);
                end else begin
                    load_valid = 1'b0;
                    load_last  = 1'b0;
                end
            end
        end
        check("str_nrdy", nrdy, 5);
        for (int i = 0; i < 5; i++) check($sformatf("str_rdy%0d", i), rdy_at[i], 5 * i);
        check("str_wecnt", we_cnt - base, 20);
        for (int i = 0; i < 5; i++) check($sformatf("str_word%0d", i), word_at(4 * i), wv[i]);
        check("str_num", d_num, 5);
        check("str_run", d_core_run, 1);
        tick();
        check("str_halt", d_halt, 1);

        // Reset in the middle of a write burst
        do_reset();
        pc = 64'd0;
        load_word(32'hCAFEF00D, 1'b0); tick();
        load_valid = 1'b1; load_data = 32'h12345678; load_last = 1'b0;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        check("mid_we",   d_mem_we, 1);
        check("mid_addr", d_mem_addr, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_ready", d_load_ready, 1);
        check("mid_we0",   d_mem_we, 0);
        check("mid_num",   d_num, 0);
        check("mid_run",   d_core_run, 0);
        check("mid_addr0", d_mem_addr, 0);
        load_word(32'h00000013, 1'b1); tick();
        check("rl_num", d_num, 1);
        check("rl_run", d_core_run, 1);
        tick();
        check("rl_halt", d_halt, 1);

        // Overflow on the MAX_WORDS=4 instance
        do_reset();
        pc = 64'd0;
        base = s_we_cnt;
        for (int i = 0; i < 4; i++) begin
            load_word(32'hA0000000 | 32'(i), 1'b0);
            tick();
        end
        check("ovf_num4",  s_num, 4);
        check("ovf_wecnt", s_we_cnt - base, 16);
        load_valid = 1'b1; load_data = 32'hDEADBEEF;
        check("ovf_offer", s_load_ready, 1);
        tick();
        load_valid = 1'b0;
        check("ovf_err",   s_error, 1);
        check("ovf_we",    s_mem_we, 0);
        check("ovf_ready", s_load_ready, 0);
        check("ovf_run",   s_core_run, 0);
        check("ovf_halt",  s_halt, 0);
        tick();
        tick();
        check("ovf_wecnt2", s_we_cnt - base, 16);
        check("ovf_num",    s_num, 4);
        check("ovf_sticky", s_error, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Sequences the byte-addressed instruction memory of the single-cycle RV64 core through two phases.
- LOAD phase: accepts 32-bit instruction words over a valid/ready stream and writes them into the memory as 4 little-endian byte writes.
- RUN phase: releases the core and monitors its program counter to raise halt at end of program, or error on a bad PC.
- Sits between the testbench/program source, the instruction memory write port and the core's run enable.

Parameters:
- ADDR_W, 14, byte-address width of instruction memory (2**ADDR_W bytes).
- MAX_WORDS, 2**(ADDR_W-2), maximum number of instruction words accepted.

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  instruction word present on load_data
- load_data  in  32  instruction word
- load_last  in  1  qualifies load_data as final word of program
- load_ready  out  1  controller can accept a word this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- program_counter_input  in  64  core PC (byte address)
- core_run  out  1  core may execute; core PC held while 0
- num_instructions  out  ADDR_W-1  words loaded so far
- halt  out  1  sticky end-of-program indication
- error  out  2  sticky code: 0 none, 1 overflow, 2 PC out of range, 3 PC misaligned

Behaviour:
- States: LOAD, WRITE0..WRITE3, RUN, HALT, ERR. All outputs are registered or decoded from state/count registers only.
- Reset (sync): state=LOAD, count=0, halt=0, error=0, core_run=0, mem_we=0, mem_addr=0, mem_wdata=0. After the reset edge, load_ready=1.
- Reset asserted in any state, including mid-WRITE, returns to this condition. Memory contents are not cleared.
- LOAD:
  - load_ready=1; word accepted on load_valid&&load_ready.
  - Capture load_data and load_last, then go to WRITE0.
  - If count==MAX_WORDS at acceptance: go to ERR, error=1, no write.
- WRITEk (k=0..3):
  - load_ready=0, mem_we=1, mem_addr=4*count+k, mem_wdata=word[8k+7:8k].
  - One byte per cycle; 4 cycles per word, no gaps.
  - In WRITE3: count increments at the edge leaving WRITE3, then next state is RUN if the captured last=1, else LOAD.
- Throughput: at most one word per 5 cycles (accept cycle + 4 write cycles). load_valid held while load_ready=0 is ignored.
- RUN:
  - core_run=1, mem_we=0.
  - Each cycle the PC checks below are evaluated in priority order: program_counter_input[63:ADDR_W]!=0 first, then program_counter_input[1:0]!=0, then the end-of-program check.
  - PC out of range (upper bits nonzero) -> ERR, error=2.
  - PC misaligned -> ERR, error=3.
  - End of program: word index program_counter_input[ADDR_W-1:2] >= count-1 -> HALT. The last instruction executes in this cycle.
- HALT: core_run=0, halt=1. Sticky until reset; inputs ignored.
- ERR: core_run=0, load_ready=0, halt=0, error holds its code. Sticky until reset.
- core_run drops on the clock edge following detection. The core sees exactly one cycle with PC at the last word.
- count never exceeds MAX_WORDS; num_instructions=count.
- Program of exactly MAX_WORDS words is legal. A further word causes error=1.

Test Plan:
- Load 3 words 0x002080B3, 0x40208133, 0x00103023 (last on third) -> 12 mem_we pulses; bytes at addr0..3 = B3,80,20,00; addr 8..11 = 23,30,10,00; num_instructions=3; core_run=1 exactly 1 cycle after final WRITE3.
- RUN after 3-word load, PC sequence 0,4,8 -> halt=1 and core_run=0 the cycle after PC=8; halt stays 1 while PC keeps changing.
- RUN with PC=0x4000 (bit 14 set, ADDR_W=14) -> error=2, core_run=0 next cycle. Separate run with PC=0x6 -> error=3.
- Hold load_valid=1 continuously with 5 words -> load_ready pulses once per 5 cycles; exactly 5 words written, none duplicated or dropped.
- Reset asserted during WRITE2 of word 1 -> next cycle state LOAD, count=0, mem_we=0, load_ready=1. Reload of 1 word with last -> num_instructions=1 and immediate halt when PC=0.
- With MAX_WORDS=4 override, load 4 words without last, then offer a 5th -> error=1, no mem_we for the 5th, num_instructions=4.
